uart_tx_frame_scheduler: RTL and testbench
==========================================

Name: uart_tx_frame_scheduler

Overview:
- Round-robin scheduler that shares one UART byte transmitter between NUM_REQ requesters.
- Wraps each granted request as a frame: HDR0, HDR1, channel ID, length, payload, XOR checksum.
- Drives the transmitter through its Send_Sig / TX_Data / TX_Done_Sig handshake, one byte at a time.
- Sits between the per-channel byte sources (FWFT FIFOs) and the UART TX control.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HDR0, 8'hEB, first sync byte.
- HDR1, 8'h90, second sync byte.
- UNDERRUN_MAX, 1024, CLK cycles a payload byte may be absent before padding starts.
- ACK_TIMEOUT, 65535, CLK cycles allowed for TX_Done_Sig to fall after Send_Sig.
- GAP_CYCLES, 16, idle CLK cycles between frames.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  reset; one clock; reset is asynchronous and active-low.
- Req  in  NUM_REQ  per-channel frame request, level.
- Req_Len  in  8*NUM_REQ  per-channel payload length 0..255; sampled at grant.
- Byte_Data  in  8*NUM_REQ  per-channel FWFT payload byte.
- Byte_Valid  in  NUM_REQ  per-channel byte available.
- Byte_Pop  out  NUM_REQ  one-cycle consume pulse, granted channel only.
- Grant  out  NUM_REQ  one-hot owner of the current frame.
- Send_Sig  out  1  one-cycle start pulse to the transmitter.
- TX_Data  out  8  byte for the transmitter; stable from Send_Sig until TX_Done_Sig rises.
- TX_Done_Sig  in  1  transmitter idle/done level: high idle, low while sending.
- Busy  out  1  frame in progress (ARB through GAP).
- Frame_Done  out  1  one-cycle pulse after the checksum byte completes.
- Err_Underrun  out  1  one-cycle pulse when payload padding starts.
- Err_Ack  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset values: all outputs 0; TX_Data=8'h00; state IDLE; round-robin pointer = NUM_REQ-1, so channel 0 wins first.
- States:
  - IDLE: any Req high -> ARB.
  - ARB: pick the first requester after the pointer, wrapping; register Grant, pointer, Req_Len; clear the checksum; byte index=0; -> LOAD. Grant is high 1 cycle after ARB is entered.
  - LOAD: select the next frame byte into TX_Data. For a payload byte with Byte_Valid low, stay in LOAD and count; the counter reaching UNDERRUN_MAX -> pulse Err_Underrun; this and all remaining payload bytes become 8'h00 and no further Byte_Pop is issued. When a byte is ready and TX_Done_Sig=1 -> SEND.
  - SEND: pulse Send_Sig for 1 cycle. For a payload byte, pulse Byte_Pop on the same cycle. Fold the byte into the checksum (ID, LEN, payload, padding included; headers excluded). -> WAIT_ACK.
  - WAIT_ACK: wait for TX_Done_Sig=0. Counter reaching ACK_TIMEOUT -> pulse Err_Ack, abort the frame (no Frame_Done), -> GAP.
  - WAIT_DONE: wait for TX_Done_Sig=1; then the last byte -> pulse Frame_Done and -> GAP, otherwise -> LOAD.
  - GAP: Grant=0; count GAP_CYCLES; -> IDLE.
- Frame byte order:
  - HDR0, HDR1.
  - ID = grant index, zero-extended to 8 bits.
  - LEN = Req_Len sampled at grant.
  - LEN payload bytes.
  - CHK = XOR of ID, LEN and all payload bytes.
  - Total frame = LEN+5 bytes. LEN=0 gives 5 bytes with CHK=ID.
- Boundary conditions:
  - Req or Req_Len changing mid-frame is ignored; the frame completes with the sampled length.
  - Byte_Valid or Byte_Data on non-granted channels is ignored.
  - Exactly LEN Byte_Pop pulses per frame, fewer only on underrun or abort.
  - A Req held high continuously is re-granted only after every other active requester has been served once.
  - RSTn low mid-frame: all state returns to reset immediately; the partial frame is not resumed.

Test Plan:
- Ch2 only, Req_Len=3, payload 11,22,33 -> TX bytes EB 90 02 03 11 22 33 01. Three Byte_Pop on ch2 only. One Frame_Done. Grant=0100 throughout.
- Req=1111 held, Req_Len=1 each -> Grant order 0001, 0010, 0100, 1000, 0001. At least GAP_CYCLES idle between frames.
- Ch1, Req_Len=0 -> EB 90 01 00 01. No Byte_Pop. Frame_Done pulses once.
- Ch0, Req_Len=2, one byte 55 then Byte_Valid low for more than UNDERRUN_MAX -> EB 90 00 02 55 00 57. One Err_Underrun. Exactly 1 Byte_Pop. Frame_Done still pulses.
- TX_Done_Sig stuck high -> after the first Send_Sig, Err_Ack at ACK_TIMEOUT. Grant drops after GAP. No Frame_Done. Next Req is served normally.
- RSTn pulsed low while the 4th byte is in WAIT_DONE -> all outputs 0 at once. After release, a new Req on ch3 gets the first grant and a full frame.

Source files
------------

// File: rtl/uart_tx_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler, the per-channel FWFT byte sources
// and the UART byte transmitter.
interface uart_tx_frame_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   Req;
  logic [8*NUM_REQ-1:0] Req_Len;
  logic [8*NUM_REQ-1:0] Byte_Data;
  logic [NUM_REQ-1:0]   Byte_Valid;
  logic [NUM_REQ-1:0]   Byte_Pop;
  logic [NUM_REQ-1:0]   Grant;
  logic                 Send_Sig;
  logic [7:0]           TX_Data;
  logic                 TX_Done_Sig;
  logic                 Busy;
  logic                 Frame_Done;
  logic                 Err_Underrun;
  logic                 Err_Ack;

  modport master (
    input  Req, Req_Len, Byte_Data, Byte_Valid, TX_Done_Sig,
    output Byte_Pop, Grant, Send_Sig, TX_Data, Busy, Frame_Done, Err_Underrun, Err_Ack
  );

  modport slave (
    output Req, Req_Len, Byte_Data, Byte_Valid, TX_Done_Sig,
    input  Byte_Pop, Grant, Send_Sig, TX_Data, Busy, Frame_Done, Err_Underrun, Err_Ack
  );
endinterface

// File: rtl/uart_tx_frame_scheduler.sv
// Round-robin frame scheduler: wraps a granted channel's payload as
// HDR0 HDR1 ID LEN payload CHK and feeds it byte by byte to one UART transmitter.
module uart_tx_frame_scheduler #(
  parameter int         NUM_REQ      = 4,
  parameter logic [7:0] HDR0         = 8'hEB,
  parameter logic [7:0] HDR1         = 8'h90,
  parameter int         UNDERRUN_MAX = 1024,
  parameter int         ACK_TIMEOUT  = 65535,
  parameter int         GAP_CYCLES   = 16
) (
  input logic                       CLK,
  input logic                       RSTn,
  uart_tx_frame_scheduler_if.master bus
);

  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX_A = (UNDERRUN_MAX > ACK_TIMEOUT) ? UNDERRUN_MAX : ACK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ARB, LOAD, SEND, WAIT_ACK, WAIT_DONE, GAP} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   gidx_reg, gidx_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [7:0]         len_reg, len_next;
  logic [8:0]         idx_reg, idx_next;
  logic [7:0]         chk_reg, chk_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic               underrun_reg, underrun_next;
  logic               frame_done_reg, frame_done_next;
  logic               err_underrun_reg, err_underrun_next;
  logic               err_ack_reg, err_ack_next;

  logic [7:0] len_lane  [NUM_REQ];
  logic [7:0] data_lane [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign len_lane[gi]  = bus.Req_Len[8*gi +: 8];
    assign data_lane[gi] = bus.Byte_Data[8*gi +: 8];
  end

  // Frame position: 0 HDR0, 1 HDR1, 2 ID, 3 LEN, 4..LEN+3 payload, LEN+4 CHK
  logic [8:0] len_ext;
  logic       is_payload, is_last, byte_ready;
  logic [7:0] id_byte, cur_byte;

  assign len_ext    = {1'b0, len_reg};
  assign is_payload = (idx_reg >= 9'd4) && (idx_reg < len_ext + 9'd4);
  assign is_last    = (idx_reg == len_ext + 9'd4);
  assign id_byte    = {{(8-IDX_W){1'b0}}, gidx_reg};
  assign byte_ready = !is_payload || underrun_reg || bus.Byte_Valid[gidx_reg];

  always_comb begin
    cur_byte = chk_reg;
    if (idx_reg == 9'd0)      cur_byte = HDR0;
    else if (idx_reg == 9'd1) cur_byte = HDR1;
    else if (idx_reg == 9'd2) cur_byte = id_byte;
    else if (idx_reg == 9'd3) cur_byte = len_reg;
    else if (is_payload)      cur_byte = underrun_reg ? 8'h00 : data_lane[gidx_reg];
  end

  // First active requester strictly after the pointer, wrapping around
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx, cand;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_reg;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!arb_found && bus.Req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    ptr_next          = ptr_reg;
    gidx_next         = gidx_reg;
    grant_next        = grant_reg;
    len_next          = len_reg;
    idx_next          = idx_reg;
    chk_next          = chk_reg;
    cnt_next          = cnt_reg;
    tx_data_next      = tx_data_reg;
    underrun_next     = underrun_reg;
    frame_done_next   = 1'b0;
    err_underrun_next = 1'b0;
    err_ack_next      = 1'b0;

    case (state_reg)
      IDLE: if (|bus.Req) state_next = ARB;

      ARB: begin
        if (arb_found) begin
          grant_next    = NUM_REQ'(1) << arb_idx;
          ptr_next      = arb_idx;
          gidx_next     = arb_idx;
          len_next      = len_lane[arb_idx];
          chk_next      = 8'h00;
          idx_next      = 9'd0;
          cnt_next      = '0;
          underrun_next = 1'b0;
          state_next    = LOAD;
        end else begin
          state_next = IDLE;
        end
      end

      LOAD: begin
        if (!byte_ready) begin
          // Once the source has starved long enough the rest of the payload is padded
          if (cnt_reg == CNT_W'(UNDERRUN_MAX - 1)) begin
            underrun_next     = 1'b1;
            err_underrun_next = 1'b1;
            cnt_next          = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else if (bus.TX_Done_Sig) begin
          tx_data_next = cur_byte;
          cnt_next     = '0;
          state_next   = SEND;
        end
      end

      SEND: begin
        if (idx_reg >= 9'd2 && !is_last) chk_next = chk_reg ^ tx_data_reg;
        cnt_next   = '0;
        state_next = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (!bus.TX_Done_Sig) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_ack_next = 1'b1;
          grant_next   = '0;
          cnt_next     = '0;
          state_next   = GAP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        if (bus.TX_Done_Sig) begin
          cnt_next = '0;
          if (is_last) begin
            frame_done_next = 1'b1;
            grant_next      = '0;
            state_next      = GAP;
          end else begin
            idx_next   = idx_reg + 9'd1;
            state_next = LOAD;
          end
        end
      end

      GAP: begin
        if (cnt_reg >= CNT_W'(GAP_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg        <= IDLE;
      ptr_reg          <= IDX_W'(NUM_REQ - 1);
      gidx_reg         <= '0;
      grant_reg        <= '0;
      len_reg          <= 8'h00;
      idx_reg          <= 9'd0;
      chk_reg          <= 8'h00;
      cnt_reg          <= '0;
      tx_data_reg      <= 8'h00;
      underrun_reg     <= 1'b0;
      frame_done_reg   <= 1'b0;
      err_underrun_reg <= 1'b0;
      err_ack_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ptr_reg          <= ptr_next;
      gidx_reg         <= gidx_next;
      grant_reg        <= grant_next;
      len_reg          <= len_next;
      idx_reg          <= idx_next;
      chk_reg          <= chk_next;
      cnt_reg          <= cnt_next;
      tx_data_reg      <= tx_data_next;
      underrun_reg     <= underrun_next;
      frame_done_reg   <= frame_done_next;
      err_underrun_reg <= err_underrun_next;
      err_ack_reg      <= err_ack_next;
    end
  end

  assign bus.Send_Sig     = (state_reg == SEND);
  assign bus.Byte_Pop     = (state_reg == SEND && is_payload && !underrun_reg) ? grant_reg : '0;
  assign bus.Grant        = grant_reg;
  assign bus.TX_Data      = tx_data_reg;
  assign bus.Busy         = (state_reg != IDLE);
  assign bus.Frame_Done   = frame_done_reg;
  assign bus.Err_Underrun = err_underrun_reg;
  assign bus.Err_Ack      = err_ack_reg;

endmodule

// File: tb/tb_uart_tx_frame_scheduler.sv
// Directed bench for uart_tx_frame_scheduler: stimulus queues expected bytes/grants,
// a negedge monitor pops and compares them as the scheduler emits them.
module tb_uart_tx_frame_scheduler;

  localparam int NR   = 4;
  localparam int UMAX = 40;
  localparam int ATO  = 100;
  localparam int GAPC = 16;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_frame_scheduler_if #(.NUM_REQ(NR)) bus();

  uart_tx_frame_scheduler #(
    .NUM_REQ(NR), .HDR0(8'hEB), .HDR1(8'h90),
    .UNDERRUN_MAX(UMAX), .ACK_TIMEOUT(ATO), .GAP_CYCLES(GAPC)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0]    data;
    logic [NR-1:0] grant;
  } exp_t;

  exp_t          exp_q[$];
  logic [NR-1:0] exp_grant_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int send_cnt    = 0;
  int fd_cnt      = 0;
  int eu_cnt      = 0;
  int ea_cnt      = 0;
  int grant_rises = 0;
  int cyc         = 0;
  int last_end    = -1;
  int pop_cnt [NR] = '{default: 0};
  logic [NR-1:0] prev_grant = '0;
  exp_t          mon_e;
  logic [NR-1:0] mon_g;

  // FWFT byte sources, one per channel
  logic [7:0]      src_mem [NR][16];
  int              src_rd  [NR] = '{default: 0};
  int              src_wr  [NR] = '{default: 0};
  logic [NR-1:0]   src_vld;
  logic [8*NR-1:0] src_dat;

  always_comb begin
    src_vld = '0;
    src_dat = '0;
    for (int c = 0; c < NR; c++) begin
      src_vld[c]         = (src_rd[c] != src_wr[c]);
      src_dat[c*8 +: 8]  = src_mem[c][src_rd[c][3:0]];
    end
  end
  assign bus.Byte_Valid = src_vld;
  assign bus.Byte_Data  = src_dat;

  always @(posedge CLK) begin
    for (int c = 0; c < NR; c++)
      if (bus.Byte_Pop[c]) src_rd[c] <= src_rd[c] + 1;
  end

  // Transmitter: goes busy one cycle after Send_Sig, idle again four cycles later
  logic tx_done_r = 1'b1;
  logic tx_stuck  = 1'b0;
  int   tx_cnt    = 0;

  always @(posedge CLK) begin
    if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done_r <= 1'b1;
    end else if (bus.Send_Sig && !tx_stuck) begin
      tx_done_r <= 1'b0;
      tx_cnt    <= 4;
    end
  end
  assign bus.TX_Done_Sig = tx_done_r;

  // Monitor / scoreboard
  always @(negedge CLK) begin
    cyc++;
    if (!RSTn) begin
      prev_grant = '0;
      last_end   = -1;
    end else begin
      if (bus.Send_Sig) begin
        send_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL tx_byte: got %02h grant %b, expected no byte", bus.TX_Data, bus.Grant);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.TX_Data !== mon_e.data || bus.Grant !== mon_e.grant) begin
            miscompares++;
            $display("FAIL tx_byte: got %02h grant %b, expected %02h grant %b",
                     bus.TX_Data, bus.Grant, mon_e.data, mon_e.grant);
          end else begin
            $display("tx_byte %02h grant %b ok", bus.TX_Data, bus.Grant);
          end
        end
      end
      for (int c = 0; c < NR; c++)
        if (bus.Byte_Pop[c]) pop_cnt[c] = pop_cnt[c] + 1;
      if (bus.Frame_Done)   begin fd_cnt++; last_end = cyc; end
      if (bus.Err_Ack)      begin ea_cnt++; last_end = cyc; end
      if (bus.Err_Underrun) eu_cnt++;
      if (bus.Grant != '0 && prev_grant == '0) begin
        grant_rises++;
        vectors++;
        if (exp_grant_q.size() == 0) begin
          miscompares++;
          $display("FAIL grant_order: got %b, expected no grant", bus.Grant);
        end else begin
          mon_g = exp_grant_q.pop_front();
          if (bus.Grant !== mon_g) begin
            miscompares++;
            $display("FAIL grant_order: got %b expected %b", bus.Grant, mon_g);
          end else begin
            $display("grant %b ok", bus.Grant);
          end
        end
        if (last_end >= 0) begin
          vectors++;
          if (cyc - last_end < GAPC) begin
            miscompares++;
            $display("FAIL frame_gap: got %0d cycles, required at least %0d", cyc - last_end, GAPC);
          end
        end
      end
      prev_grant = bus.Grant;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic push_seq(input logic [NR-1:0] g, input int n, input logic [7:0] b [8]);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data  = b[i];
      e.grant = g;
      exp_q.push_back(e);
    end
  endtask

  task automatic load_src(input int ch, input int n, input logic [7:0] b [4]);
    for (int i = 0; i < n; i++) begin
      src_mem[ch][src_wr[ch][3:0]] = b[i];
      src_wr[ch] = src_wr[ch] + 1;
    end
  endtask

  task automatic flush_src();
    for (int c = 0; c < NR; c++) src_wr[c] = src_rd[c];
  endtask

  task automatic wait_rises(input int n, input int budget);
    int target;
    int k;
    target = grant_rises + n;
    k = 0;
    while (grant_rises < target && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk("grant_wait", int'(grant_rises >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (bus.Busy && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk("idle_wait", int'(bus.Busy), 0);
  endtask

  task automatic check_counts(input string tag, input int p0, input int p1, input int p2,
                              input int p3, input int fd, input int eu, input int ea);
    chk({tag, "_pop0"}, pop_cnt[0], p0);
    chk({tag, "_pop1"}, pop_cnt[1], p1);
    chk({tag, "_pop2"}, pop_cnt[2], p2);
    chk({tag, "_pop3"}, pop_cnt[3], p3);
    chk({tag, "_frame_done"}, fd_cnt, fd);
    chk({tag, "_err_underrun"}, eu_cnt, eu);
    chk({tag, "_err_ack"}, ea_cnt, ea);
    chk({tag, "_bytes_left"}, exp_q.size(), 0);
    chk({tag, "_grants_left"}, exp_grant_q.size(), 0);
    for (int c = 0; c < NR; c++) pop_cnt[c] = 0;
    fd_cnt = 0;
    eu_cnt = 0;
    ea_cnt = 0;
  endtask

  // Request one frame on a single channel and run it to completion
  task automatic serve_one(input int ch, input int len, input int budget);
    exp_grant_q.push_back(NR'(1) << ch);
    bus.Req_Len[ch*8 +: 8] = 8'(len);
    bus.Req[ch] = 1'b1;
    wait_rises(1, budget);
    bus.Req[ch] = 1'b0;
    wait_idle(budget);
  endtask

  function automatic int all_outputs();
    return int'({bus.Busy, bus.Send_Sig, bus.Frame_Done, bus.Err_Underrun, bus.Err_Ack,
                 bus.Grant, bus.Byte_Pop, bus.TX_Data});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] v [8];
    logic [7:0] s [4];
    int target;
    int k;

    bus.Req     = '0;
    bus.Req_Len = '0;
    RSTn        = 1'b0;
    @(negedge CLK);
    chk("reset_outputs", all_outputs(), 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("post_reset_outputs", all_outputs(), 0);

    // All four requesting, one byte each: 0,1,2,3 then 0 again
    s = '{8'hA0, 8'hE0, 8'h00, 8'h00}; load_src(0, 2, s);
    s = '{8'hB1, 8'h00, 8'h00, 8'h00}; load_src(1, 1, s);
    s = '{8'hC2, 8'h00, 8'h00, 8'h00}; load_src(2, 1, s);
    s = '{8'hD3, 8'h00, 8'h00, 8'h00}; load_src(3, 1, s);
    v = '{8'hEB, 8'h90, 8'h00, 8'h01, 8'hA0, 8'hA1, 8'h00, 8'h00}; push_seq(4'b0001, 6, v);
    v = '{8'hEB, 8'h90, 8'h01, 8'h01, 8'hB1, 8'hB1, 8'h00, 8'h00}; push_seq(4'b0010, 6, v);
    v = '{8'hEB, 8'h90, 8'h02, 8'h01, 8'hC2, 8'hC1, 8'h00, 8'h00}; push_seq(4'b0100, 6, v);
    v = '{8'hEB, 8'h90, 8'h03, 8'h01, 8'hD3, 8'hD1, 8'h00, 8'h00}; push_seq(4'b1000, 6, v);
    v = '{8'hEB, 8'h90, 8'h00, 8'h01, 8'hE0, 8'hE1, 8'h00, 8'h00}; push_seq(4'b0001, 6, v);
    exp_grant_q.push_back(4'b0001);
    exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0100);
    exp_grant_q.push_back(4'b1000);
    exp_grant_q.push_back(4'b0001);
    bus.Req_Len = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.Req     = 4'b1111;
    wait_rises(5, 2000);
    bus.Req = '0;
    wait_idle(500);
    check_counts("rr", 2, 1, 1, 1, 5, 0, 0);

    // Ch2, three payload bytes; Req_Len changed mid-frame must be ignored
    s = '{8'h11, 8'h22, 8'h33, 8'h00}; load_src(2, 3, s);
    v = '{8'hEB, 8'h90, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01}; push_seq(4'b0100, 8, v);
    exp_grant_q.push_back(4'b0100);
    bus.Req_Len[2*8 +: 8] = 8'd3;
    bus.Req[2] = 1'b1;
    wait_rises(1, 200);
    bus.Req[2] = 1'b0;
    bus.Req_Len[2*8 +: 8] = 8'd9;
    wait_idle(500);
    check_counts("ch2_len3", 0, 0, 3, 0, 1, 0, 0);

    // Ch1, empty payload
    v = '{8'hEB, 8'h90, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00}; push_seq(4'b0010, 5, v);
    serve_one(1, 0, 500);
    check_counts("ch1_len0", 0, 0, 0, 0, 1, 0, 0);

    // Ch0, one byte then starvation: padding and one underrun pulse
    s = '{8'h55, 8'h00, 8'h00, 8'h00}; load_src(0, 1, s);
    v = '{8'hEB, 8'h90, 8'h00, 8'h02, 8'h55, 8'h00, 8'h57, 8'h00}; push_seq(4'b0001, 7, v);
    serve_one(0, 2, 600);
    check_counts("ch0_underrun", 1, 0, 0, 0, 1, 1, 0);

    // Transmitter never acknowledges: abort after the first byte
    flush_src();
    tx_stuck = 1'b1;
    s = '{8'h77, 8'h00, 8'h00, 8'h00}; load_src(2, 1, s);
    v = '{8'hEB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; push_seq(4'b0100, 1, v);
    serve_one(2, 1, 600);
    chk("ack_abort_grant", int'(bus.Grant), 0);
    check_counts("ack_abort", 0, 0, 0, 0, 0, 0, 1);
    tx_stuck = 1'b0;
    flush_src();

    v = '{8'hEB, 8'h90, 8'h03, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00}; push_seq(4'b1000, 5, v);
    serve_one(3, 0, 500);
    check_counts("after_abort", 0, 0, 0, 0, 1, 0, 0);

    // Reset while the LEN byte is being transmitted
    s = '{8'h12, 8'h34, 8'h00, 8'h00}; load_src(0, 2, s);
    v = '{8'hEB, 8'h90, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}; push_seq(4'b0001, 4, v);
    exp_grant_q.push_back(4'b0001);
    target = send_cnt + 4;
    bus.Req_Len[0 +: 8] = 8'd2;
    bus.Req[0] = 1'b1;
    k = 0;
    while (send_cnt < target && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk("reset_test_sends", int'(send_cnt >= target), 1);
    bus.Req = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("busy_before_reset", int'(bus.Busy), 1);
    chk("txdata_before_reset", int'(bus.TX_Data), 8'h02);
    #2 RSTn = 1'b0;
    #1 chk("reset_midframe_outputs", all_outputs(), 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    flush_src();
    check_counts("reset_abort", 0, 0, 0, 0, 0, 0, 0);

    s = '{8'hC3, 8'h00, 8'h00, 8'h00}; load_src(3, 1, s);
    v = '{8'hEB, 8'h90, 8'h03, 8'h01, 8'hC3, 8'hC1, 8'h00, 8'h00}; push_seq(4'b1000, 6, v);
    serve_one(3, 1, 500);
    check_counts("post_reset_ch3", 0, 0, 0, 1, 1, 0, 0);

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
